// File: rtl/alarm_timer_sched_if.sv
// Bus bundle for the shared alarm timer scheduler.
//   master : requester side, drives start/cancel/tick and observes the timer
//   slave  : scheduler side, drives grant/done/busy/count
//   start  [2:0]   per-requester request level
//   cancel [2:0]   per-requester abort
//   tick           timebase enable
//   grant  [2:0]   one-hot current owner, 0 when idle
//   done   [2:0]   one-cycle expiry pulse on the owner bit
//   busy           timer occupied (RUN or DONE)
//   count  [CW-1:0] remaining ticks of the current owner
interface alarm_timer_sched_if #(
    parameter int CW = 4
);
    logic [2:0]    start;
    logic [2:0]    cancel;
    logic          tick;
    logic [2:0]    grant;
    logic [2:0]    done;
    logic          busy;
    logic [CW-1:0] count;

    modport master (
        output start, cancel, tick,
        input  grant, done, busy, count
    );

    modport slave (
        input  start, cancel, tick,
        output grant, done, busy, count
    );
endinterface

// File: rtl/alarm_timer_sched.sv
// Scheduler for the single countdown timer shared by the car-alarm FSM.
// Requesters: 0 = siren duration, 1 = entry delay, 2 = arming delay.
// Requests queue in pend, the lowest pending index wins when idle, and the
// owner is counted down on tick edges, then gets a one-cycle done pulse.
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   bus (slave)  start/cancel/tick in, grant/done/busy/count out
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; grants the lowest pending request
// RUN   | owner counting down on tick; cancel/retrigger handled here
// DONE  | expiry cycle; done = grant for one cycle, then back to IDLE
module alarm_timer_sched #(
    parameter int CW      = 4,
    parameter int T_SIREN = 10,
    parameter int T_ENTRY = 3,
    parameter int T_ARM   = 6
) (
    input logic                clock,
    input logic                reset,
    alarm_timer_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Load values are truncated to the counter width.
    localparam logic [CW-1:0] LOAD_0 = CW'(T_SIREN);
    localparam logic [CW-1:0] LOAD_1 = CW'(T_ENTRY);
    localparam logic [CW-1:0] LOAD_2 = CW'(T_ARM);

    function automatic logic [CW-1:0] load_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return LOAD_0;
            2'd1:    return LOAD_1;
            default: return LOAD_2;
        endcase
    endfunction

    state_t        state_q, state_nxt;
    logic [2:0]    pend_q, pend_nxt;
    logic [2:0]    grant_q, grant_nxt;
    logic [2:0]    done_q, done_nxt;
    logic [1:0]    owner_q, owner_nxt;
    logic [CW-1:0] count_q, count_nxt;
    logic [1:0]    sel;
    logic          found;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            owner_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_nxt;
            pend_q  <= pend_nxt;
            grant_q <= grant_nxt;
            done_q  <= done_nxt;
            owner_q <= owner_nxt;
            count_q <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        pend_nxt  = pend_q;
        grant_nxt = grant_q;
        done_nxt  = '0;
        owner_nxt = owner_q;
        count_nxt = count_q;
        sel       = '0;
        found     = 1'b0;

        // While running, start on the owner is a retrigger, not a new request.
        // In DONE it queues a fresh request for after the return to IDLE.
        for (int i = 0; i < 3; i++) begin
            if (bus.start[i] && !(state_q == RUN && owner_q == 2'(i))) begin
                pend_nxt[i] = 1'b1;
            end
        end

        // Descending scan so the lowest pending index is the one kept.
        for (int i = 2; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel   = 2'(i);
                found = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_nxt     = RUN;
                    owner_nxt     = sel;
                    grant_nxt     = 3'b001 << sel;
                    count_nxt     = load_of(sel);
                    pend_nxt[sel] = 1'b0;
                end
            end
            RUN: begin
                if (bus.cancel[owner_q]) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    count_nxt = '0;
                end else if (bus.start[owner_q]) begin
                    count_nxt = load_of(owner_q);
                end else if (count_q == '0 || (bus.tick && count_q == CW'(1))) begin
                    state_nxt = DONE;
                    count_nxt = '0;
                    done_nxt  = grant_q;
                end else if (bus.tick) begin
                    count_nxt = count_q - CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                count_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                count_nxt = '0;
            end
        endcase

        // Cancel wins over a same-edge start.
        pend_nxt = pend_nxt & ~bus.cancel;
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_alarm_timer_sched.sv
module tb_alarm_timer_sched;

    logic clock = 1'b0;
    logic reset = 1'b0;

    alarm_timer_sched_if #(.CW(4)) bus ();

    alarm_timer_sched #(
        .CW(4), .T_SIREN(10), .T_ENTRY(3), .T_ARM(6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 = none), ticks remaining,
    // expiry flag for the pulse cycle, and the set of waiting requesters.
    int       tval[3] = '{10, 3, 6};
    int       m_owner;
    int       m_remain;
    bit       m_expired;
    bit [2:0] m_pend;

    typedef struct {
        logic [2:0] start;
        logic [2:0] cancel;
        logic       tick;
        logic [2:0] exp_grant;
        logic [2:0] exp_done;
        logic       exp_busy;
        logic [3:0] exp_count;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_remain  = 0;
        m_expired = 1'b0;
        m_pend    = '0;
    endtask

    task automatic model_step(input logic [2:0] s, input logic [2:0] c, input logic t);
        bit [2:0] np;
        int       pick;
        np   = m_pend;
        pick = -1;
        for (int i = 0; i < 3; i++) begin
            if (s[i] && !(m_owner == i && !m_expired)) np[i] = 1'b1;
        end
        if (m_owner < 0) begin
            for (int i = 0; i < 3; i++) begin
                if (m_pend[i] && pick < 0) pick = i;
            end
            if (pick >= 0) begin
                m_owner  = pick;
                m_remain = tval[pick] % 16;
                np[pick] = 1'b0;
            end
        end else if (m_expired) begin
            m_owner   = -1;
            m_expired = 1'b0;
            m_remain  = 0;
        end else if (c[m_owner]) begin
            m_owner  = -1;
            m_remain = 0;
        end else if (s[m_owner]) begin
            m_remain = tval[m_owner] % 16;
        end else if (m_remain == 0 || (t && m_remain == 1)) begin
            m_remain  = 0;
            m_expired = 1'b1;
        end else if (t) begin
            m_remain = m_remain - 1;
        end
        m_pend = np & ~c;
    endtask

    task automatic check_model();
        logic [2:0] eg;
        eg = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
        chk("model_grant", 32'(bus.grant), 32'(eg));
        chk("model_done",  32'(bus.done),  m_expired ? 32'(eg) : 32'd0);
        chk("model_busy",  32'(bus.busy),  (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("model_count", 32'(bus.count), 32'(m_remain));
    endtask

    task automatic cycle(input logic [2:0] s, input logic [2:0] c, input logic t);
        bus.start  = s;
        bus.cancel = c;
        bus.tick   = t;
        @(posedge clock);
        model_step(s, c, t);
        #1;
        check_model();
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) cycle(3'b111, 3'b111, 1'b0);
        cycle(3'b000, 3'b111, 1'b0);
        cycle(3'b000, 3'b000, 1'b0);
        chk("drain_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int done_cyc[3];
        logic [2:0] done_bit[3];
        int grant_cyc;
        int nd;
        int found;
        logic       t5[6];
        logic [3:0] c5[6];

        bus.start  = '0;
        bus.cancel = '0;
        bus.tick   = 1'b0;
        model_reset();

        // Vectors for a single entry-delay request with tick held high.
        vecs[0] = '{3'b010, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 4'd0};
        vecs[1] = '{3'b000, 3'b000, 1'b1, 3'b010, 3'b000, 1'b1, 4'd3};
        vecs[2] = '{3'b000, 3'b000, 1'b1, 3'b010, 3'b000, 1'b1, 4'd2};
        vecs[3] = '{3'b000, 3'b000, 1'b1, 3'b010, 3'b000, 1'b1, 4'd1};
        vecs[4] = '{3'b000, 3'b000, 1'b1, 3'b010, 3'b010, 1'b1, 4'd0};
        vecs[5] = '{3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 4'd0};
        vecs[6] = '{3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 4'd0};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_done",  32'(bus.done),  32'd0);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            cycle(vecs[v].start, vecs[v].cancel, vecs[v].tick);
            chk("tbl_grant", 32'(bus.grant), 32'(vecs[v].exp_grant));
            chk("tbl_done",  32'(bus.done),  32'(vecs[v].exp_done));
            chk("tbl_busy",  32'(bus.busy),  32'(vecs[v].exp_busy));
            chk("tbl_count", 32'(bus.count), 32'(vecs[v].exp_count));
        end

        // All three at once: served 0, 1, 2.
        drain();
        cycle(3'b111, 3'b000, 1'b1);
        nd = 0;
        grant_cyc = -1;
        for (int k = 1; k <= 100 && nd < 3; k++) begin
            cycle(3'b000, 3'b000, 1'b1);
            if (grant_cyc < 0 && bus.grant == 3'b001) grant_cyc = k;
            if (bus.done != 3'b000) begin
                done_cyc[nd] = k;
                done_bit[nd] = bus.done;
                nd++;
            end
        end
        chk("all3_count", 32'(nd), 32'd3);
        if (nd == 3) begin
            chk("all3_first_bit", 32'(done_bit[0]), 32'b001);
            chk("all3_second_bit", 32'(done_bit[1]), 32'b010);
            chk("all3_third_bit", 32'(done_bit[2]), 32'b100);
            chk("all3_first_lat", 32'(done_cyc[0] - grant_cyc), 32'd10);
            chk("all3_gap01", 32'(done_cyc[1] - done_cyc[0]), 32'd5);
            chk("all3_gap12", 32'(done_cyc[2] - done_cyc[1]), 32'd8);
        end

        // Owner cancel mid-run.
        drain();
        cycle(3'b100, 3'b000, 1'b1);
        cycle(3'b000, 3'b000, 1'b1);
        chk("cancel_load", 32'(bus.count), 32'd6);
        cycle(3'b000, 3'b000, 1'b1);
        cycle(3'b000, 3'b000, 1'b1);
        chk("cancel_pre", 32'(bus.count), 32'd4);
        cycle(3'b000, 3'b100, 1'b1);
        chk("cancel_grant", 32'(bus.grant), 32'd0);
        chk("cancel_count", 32'(bus.count), 32'd0);
        chk("cancel_busy",  32'(bus.busy),  32'd0);
        chk("cancel_done",  32'(bus.done),  32'd0);
        cycle(3'b000, 3'b000, 1'b1);
        chk("cancel_nodone", 32'(bus.done), 32'd0);

        // Retrigger at count 2 reloads the full siren time.
        drain();
        cycle(3'b001, 3'b000, 1'b1);
        cycle(3'b000, 3'b000, 1'b1);
        repeat (8) cycle(3'b000, 3'b000, 1'b1);
        chk("retrig_pre", 32'(bus.count), 32'd2);
        cycle(3'b001, 3'b000, 1'b1);
        chk("retrig_reload", 32'(bus.count), 32'd10);
        found = -1;
        for (int k = 1; k <= 20 && found < 0; k++) begin
            cycle(3'b000, 3'b000, 1'b1);
            if (bus.done == 3'b001) found = k;
        end
        chk("retrig_lat", 32'(found), 32'd10);

        // Tick toggling on the entry delay; count holds on tick=0.
        drain();
        cycle(3'b010, 3'b000, 1'b0);
        cycle(3'b000, 3'b000, 1'b0);
        chk("toggle_load", 32'(bus.count), 32'd3);
        t5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        c5 = '{4'd3, 4'd2, 4'd2, 4'd1, 4'd1, 4'd0};
        for (int k = 0; k < 6; k++) begin
            cycle(3'b000, 3'b000, t5[k]);
            chk("toggle_count", 32'(bus.count), 32'(c5[k]));
            chk("toggle_done", 32'(bus.done), (k == 5) ? 32'b010 : 32'd0);
        end

        // Asynchronous reset while running with requests 0 and 2 queued.
        drain();
        cycle(3'b010, 3'b000, 1'b1);
        cycle(3'b000, 3'b000, 1'b1);
        cycle(3'b101, 3'b000, 1'b1);
        chk("arst_pre_busy", 32'(bus.busy), 32'd1);
        chk("arst_pre_pend", 32'(m_pend), 32'b101);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_grant", 32'(bus.grant), 32'd0);
        chk("arst_done",  32'(bus.done),  32'd0);
        chk("arst_busy",  32'(bus.busy),  32'd0);
        chk("arst_count", 32'(bus.count), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(3'b000, 3'b000, 1'b1);
            chk("arst_idle_grant", 32'(bus.grant), 32'd0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            logic [2:0] s;
            logic [2:0] c;
            logic       t;
            s = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            c = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            t = 1'($urandom_range(0, 1));
            cycle(s, c, t);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
